// File: rtl/sobel_pkg.sv
// Shared Sobel pipeline types and frame geometry.
// Used by the pixel streamer, line buffer and filter stages.
package sobel_pkg;

    localparam int WIDTH  = 128;
    localparam int HEIGHT = 128;
    localparam int AW     = 14;
    localparam int COL_W  = 7;
    localparam int ROW_W  = 8;
    localparam int RA_W   = AW - COL_W;

    typedef enum logic [2:0] {
        S_IDLE,
        S_PRIME,
        S_STREAM,
        S_FLUSH,
        S_FIN
    } state_t;

endpackage

// File: rtl/frame_pixel_streamer_if.sv
// Frame streamer bus: control, frame memory read port and beat output.
// master = streamer side, slave = memory/line-buffer/controller side.
interface frame_pixel_streamer_if;
    import sobel_pkg::*;

    logic             start;
    logic             hold;
    logic             mem_en;
    logic [AW-1:0]    mem_addr;
    logic [7:0]       mem_rdata;
    logic [7:0]       pixel_out;
    logic             enable;
    logic [ROW_W-1:0] row_count;
    logic [COL_W-1:0] col_count;
    logic             busy;
    logic             done;

    modport master (
        input  start, hold, mem_rdata,
        output mem_en, mem_addr, pixel_out, enable,
        output row_count, col_count, busy, done
    );

    modport slave (
        output start, hold, mem_rdata,
        input  mem_en, mem_addr, pixel_out, enable,
        input  row_count, col_count, busy, done
    );

endinterface

// File: rtl/raster_counter.sv
// Raster position counter (fetch side) with column wrap and row carry.
// Flags mark the last column, the flush row and the final flush position.
module raster_counter
    import sobel_pkg::*;
(
    input  logic             clk,
    input  logic             xrst,
    input  logic             clear,
    input  logic             step,
    output logic [ROW_W-1:0] row,
    output logic [COL_W-1:0] col,
    output logic             last_col,
    output logic             flush_row,
    output logic             last_pos
);

    assign last_col  = (col == COL_W'(WIDTH - 1));
    assign flush_row = (row == ROW_W'(HEIGHT));
    assign last_pos  = flush_row & last_col;

    // advance one raster position per step; frozen when step is low
    always_ff @(posedge clk or negedge xrst) begin
        if (!xrst) begin
            row <= '0;
            col <= '0;
        end else if (clear) begin
            row <= '0;
            col <= '0;
        end else if (step) begin
            col <= last_col ? '0 : col + 1'b1;
            if (last_col) begin
                row <= row + 1'b1;
            end
        end
    end

endmodule

// File: rtl/frame_pixel_streamer.sv
// Raster-scan frame source for the 3x3 window line buffer.
// Streams HEIGHT rows then replays the bottom row once as a flush row.
module frame_pixel_streamer
    import sobel_pkg::*;
(
    input logic                    clk,
    input logic                    xrst,
    frame_pixel_streamer_if.master bus
);

    state_t           state;
    logic             pending;
    logic             busy_q;
    logic             done_q;
    logic             mem_en_q;
    logic [ROW_W-1:0] row_q;
    logic [COL_W-1:0] col_q;

    logic [ROW_W-1:0] f_row;
    logic [COL_W-1:0] f_col;
    logic             f_last_col;
    logic             f_flush;
    logic             f_end;

    logic             issue;
    logic             clear;
    logic             step;
    logic [RA_W-1:0]  addr_row;

    // fetch counter runs one position ahead of the beat on the bus
    assign issue = pending & ~bus.hold;
    assign clear = (state == S_IDLE) & bus.start;
    assign step  = ~bus.hold & ((state == S_PRIME) | pending) & ~f_end;

    raster_counter u_cnt (
        .clk       (clk),
        .xrst      (xrst),
        .clear     (clear),
        .step      (step),
        .row       (f_row),
        .col       (f_col),
        .last_col  (f_last_col),
        .flush_row (f_flush),
        .last_pos  (f_end)
    );

    // flush row re-reads the bottom image row
    assign addr_row = f_flush ? RA_W'(HEIGHT - 1) : f_row[RA_W-1:0];

    assign bus.mem_addr  = {addr_row, f_col};
    assign bus.mem_en    = mem_en_q & ~bus.hold;
    assign bus.pixel_out = bus.mem_rdata;
    assign bus.enable    = issue;
    assign bus.row_count = row_q;
    assign bus.col_count = col_q;
    assign bus.busy      = busy_q;
    assign bus.done      = done_q;

    // frame sequencer: prime first read, stream, flush, pulse done
    always_ff @(posedge clk or negedge xrst) begin
        if (!xrst) begin
            state    <= S_IDLE;
            pending  <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            mem_en_q <= 1'b0;
            row_q    <= '0;
            col_q    <= '0;
        end else begin
            done_q <= 1'b0;
            unique case (state)
                S_IDLE: begin
                    if (bus.start) begin
                        state    <= S_PRIME;
                        busy_q   <= 1'b1;
                        mem_en_q <= 1'b1;
                    end
                end
                S_PRIME: begin
                    if (!bus.hold) begin
                        state   <= S_STREAM;
                        pending <= 1'b1;
                        row_q   <= f_row;
                        col_q   <= f_col;
                    end
                end
                S_STREAM: begin
                    if (issue) begin
                        row_q <= f_row;
                        col_q <= f_col;
                        if (f_flush) begin
                            state <= S_FLUSH;
                        end
                    end
                end
                S_FLUSH: begin
                    if (issue) begin
                        if (col_q == COL_W'(WIDTH - 1)) begin
                            state    <= S_FIN;
                            pending  <= 1'b0;
                            busy_q   <= 1'b0;
                            done_q   <= 1'b1;
                            mem_en_q <= 1'b0;
                        end else begin
                            row_q <= f_row;
                            col_q <= f_col;
                        end
                    end
                end
                S_FIN: begin
                    state <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_frame_pixel_streamer.sv
// Randomized bench for frame_pixel_streamer against a raster-order model.
// Memory holds mem[a] = a[7:0]; beats are collected and compared per frame.
module tb_frame_pixel_streamer;
    import sobel_pkg::*;

    typedef struct packed {
        logic [7:0] r;
        logic [6:0] c;
        logic [7:0] p;
    } beat_t;

    localparam int NBEAT = (HEIGHT + 1) * WIDTH;

    logic clk;
    logic xrst;

    frame_pixel_streamer_if bus();

    frame_pixel_streamer u_dut (
        .clk  (clk),
        .xrst (xrst),
        .bus  (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // synchronous-read frame memory, content = low address byte
    always @(posedge clk) begin
        if (bus.mem_en) begin
            bus.mem_rdata <= bus.mem_addr[7:0];
        end
    end

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int start_cyc = -100;
    int first_beat = -1;
    int last_beat = -1;
    int done_cyc = -1;
    int done_cnt = 0;
    bit prev_hold = 0;
    bit prev_busy = 0;
    logic [AW-1:0] prev_addr = '0;
    bit smp_en = 0;
    bit smp_done = 0;
    beat_t smp_beat;
    beat_t exp_q[$];
    beat_t got_q[$];
    beat_t ref_q[$];

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic build_model();
        for (int r = 0; r <= HEIGHT; r++) begin
            for (int c = 0; c < WIDTH; c++) begin
                int src;
                beat_t b;
                src = (r < HEIGHT) ? r : HEIGHT - 1;
                b.r = 8'(r);
                b.c = 7'(c);
                b.p = 8'((src * WIDTH + c) & 255);
                exp_q.push_back(b);
            end
        end
    endtask

    task automatic sample(input bit h, input bit s);
        cyc++;
        if (prev_hold && prev_busy) begin
            check("addr_frozen", 32'(bus.mem_addr), 32'(prev_addr));
        end
        prev_hold = h;
        prev_busy = bus.busy;
        prev_addr = bus.mem_addr;
        if (s && !bus.busy && !bus.done) start_cyc = cyc;
        smp_en = bus.enable;
        smp_done = bus.done;
        smp_beat = '{r: bus.row_count, c: bus.col_count, p: bus.pixel_out};
        if (bus.enable) begin
            if (got_q.size() == 0) first_beat = cyc;
            got_q.push_back(smp_beat);
            last_beat = cyc;
        end
        if (bus.done) begin
            done_cnt++;
            done_cyc = cyc;
        end
    endtask

    task automatic step(input bit h, input bit s);
        bus.hold = h;
        bus.start = s;
        #2;
        sample(h, s);
        @(posedge clk);
        #1;
    endtask

    task automatic reset_dut();
        xrst = 1'b0;
        bus.start = 1'b0;
        bus.hold = 1'b0;
        @(posedge clk);
        #1;
        xrst = 1'b1;
        prev_hold = 0;
        prev_busy = 0;
    endtask

    task automatic clear_log();
        got_q.delete();
        done_cnt = 0;
        first_beat = -1;
        last_beat = -1;
        done_cyc = -1;
        start_cyc = -100;
    endtask

    task automatic run_frame(input bit rnd, input bit noise);
        int n;
        bit fin, fin_nx, h, s, did;
        clear_log();
        step(1'b0, 1'b1);
        n = 0;
        fin = 0;
        fin_nx = 0;
        did = 0;
        while (!fin && n < 40000) begin
            if (rnd && !did && bus.busy && bus.row_count == 8'd0 &&
                bus.col_count == 7'd127) begin
                did = 1;
                for (int i = 0; i < 5; i++) begin
                    step(1'b1, 1'b0);
                    check("held_rc",
                          32'({bus.row_count, bus.col_count}),
                          32'({8'd0, 7'd127}));
                end
            end
            h = rnd && ($urandom_range(99) < 30);
            s = fin_nx || (noise && bus.busy && $urandom_range(9) == 0);
            step(h, s);
            n++;
            fin_nx = noise && smp_en && smp_beat.r == 8'd128 &&
                     smp_beat.c == 7'd127;
            if (smp_done) fin = 1;
        end
        check("frame_timeout", 32'(fin), 32'd1);
    endtask

    task automatic check_frame(input bit timed);
        int nb;
        nb = got_q.size();
        check("beat_count", 32'(nb), 32'(NBEAT));
        for (int i = 0; i < NBEAT; i++) begin
            if (i < nb) begin
                check($sformatf("beat%0d", i), 32'(got_q[i]), 32'(exp_q[i]));
            end
        end
        check("done_count", 32'(done_cnt), 32'd1);
        check("done_latency", 32'(done_cyc - last_beat), 32'd1);
        if (timed) begin
            check("beat_span", 32'(last_beat - first_beat), 32'(NBEAT - 1));
            check("first_latency", 32'(first_beat - start_cyc), 32'd2);
        end
    endtask

    initial begin
        int n;
        int diff;
        build_model();
        bus.start = 1'b0;
        bus.hold = 1'b0;
        xrst = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_enable", 32'(bus.enable), 32'd0);
        check("rst_busy", 32'(bus.busy), 32'd0);
        check("rst_done", 32'(bus.done), 32'd0);
        check("rst_mem_en", 32'(bus.mem_en), 32'd0);
        check("rst_addr", 32'(bus.mem_addr), 32'd0);
        check("rst_row", 32'(bus.row_count), 32'd0);
        check("rst_col", 32'(bus.col_count), 32'd0);
        xrst = 1'b1;
        @(posedge clk);
        #1;

        clear_log();
        step(1'b0, 1'b1);
        n = 0;
        while (bus.row_count != 8'd5 && n < 2000) begin
            step(1'b0, 1'b0);
            n++;
        end
        check("reach_row5", 32'(bus.row_count), 32'd5);
        #2;
        xrst = 1'b0;
        #1;
        check("midrst_enable", 32'(bus.enable), 32'd0);
        check("midrst_busy", 32'(bus.busy), 32'd0);
        check("midrst_done", 32'(bus.done), 32'd0);
        @(posedge clk);
        #1;
        xrst = 1'b1;
        prev_hold = 0;
        prev_busy = 0;
        clear_log();
        step(1'b0, 1'b1);
        step(1'b0, 1'b0);
        step(1'b0, 1'b0);
        check("restart_latency", 32'(first_beat - start_cyc), 32'd2);
        check("restart_beat0",
              got_q.size() > 0 ? 32'(got_q[0]) : 32'hffff_ffff, 32'd0);
        check("restart_no_done", 32'(done_cnt), 32'd0);
        reset_dut();

        run_frame(1'b0, 1'b0);
        check_frame(1'b1);
        ref_q = got_q;

        run_frame(1'b0, 1'b1);
        for (int i = 0; i < 4; i++) step(1'b0, 1'b0);
        check_frame(1'b1);
        check("idle_busy", 32'(bus.busy), 32'd0);
        diff = 0;
        for (int i = 0; i < got_q.size(); i++) begin
            if (i >= ref_q.size() || got_q[i] !== ref_q[i]) diff++;
        end
        check("b2b_diff", 32'(diff), 32'd0);

        run_frame(1'b1, 1'b0);
        check_frame(1'b0);
        check("release_beat",
              got_q.size() > 128 ? 32'(got_q[128]) : 32'hffff_ffff,
              32'({8'd1, 7'd0, 8'd128}));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
